// File: rtl/avalon_mm_mem_slave_pkg.sv
// Shared constants and width helpers for the Avalon-MM memory slave.
package avalon_mem_pkg;

  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_RANGE = 0;
  localparam int unsigned ERR_RDWR  = 1;
  localparam int unsigned ERR_LOAD  = 2;

  // Counter widths are never allowed to collapse to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned idx_w(input int unsigned depth);
    return clog2_min1(depth);
  endfunction

  function automatic int unsigned byte_sh(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/avalon_mm_mem_slave_read.sv
// Fixed-latency read return path: valid+data shift register, cleared by reset.
module avs_read_pipe #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [DATA_W-1:0]  dat [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_data;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];

endmodule

// File: rtl/avalon_mm_mem_slave.sv
// Parametrised Avalon-MM slave memory with fixed stall, pipelined reads and
// a side load/peek port for preloading operands and checking results.
module avalon_mm_mem_slave
  import avalon_mem_pkg::*;
#(
  parameter  int unsigned DATA_W       = 256,
  parameter  int unsigned ADDR_W       = 32,
  parameter  int unsigned DEPTH        = 64,
  parameter  int unsigned WAIT_CYCLES  = 3,
  parameter  int unsigned READ_LATENCY = 2,
  parameter  int unsigned MAX_PENDING  = 4,
  localparam int unsigned IDX_W        = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              load_we,
  input  logic [IDX_W-1:0]  load_index,
  input  logic [DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]  peek_index,
  output logic [DATA_W-1:0] peek_data,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [ERR_W-1:0]  err_flags
);

  localparam int unsigned BYTE_SH = byte_sh(DATA_W);
  localparam int unsigned SC_W    = clog2_min1(WAIT_CYCLES + 1);
  localparam int unsigned PN_W    = clog2_min1(MAX_PENDING + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [SC_W-1:0]   stall_cnt;
  logic [PN_W-1:0]   pending;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic              in_range, load_ok, peek_ok;
  logic              cmd, pend_full, accept, rd_accept, wr_accept;
  logic [DATA_W-1:0] rd_word;

  assign word_addr = avs_address >> BYTE_SH;
  assign idx       = word_addr[IDX_W-1:0];
  assign in_range  = word_addr < ADDR_W'(DEPTH);
  assign load_ok   = {1'b0, load_index} < (IDX_W + 1)'(DEPTH);
  assign peek_ok   = {1'b0, peek_index} < (IDX_W + 1)'(DEPTH);

  assign cmd = avs_read | avs_write;
  // A return leaving this cycle frees its slot, so a full pipe can accept
  // again in the same cycle its oldest read completes.
  assign pend_full       = (pending - PN_W'(avs_readdatavalid)) == PN_W'(MAX_PENDING);
  assign avs_waitrequest = cmd & ((stall_cnt != SC_W'(WAIT_CYCLES)) | (avs_read & pend_full));
  assign accept          = cmd & ~avs_waitrequest;
  assign rd_accept       = accept & avs_read;
  assign wr_accept       = accept & ~avs_read;

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[idx];
      if (load_we && load_index == idx) rd_word = load_data;
    end
  end

  assign peek_data = peek_ok ? mem[peek_index] : '0;

  // Load port is written last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) mem[idx] <= avs_writedata;
    if (load_we && load_ok)    mem[load_index] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      pending   <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      err_flags <= '0;
    end else begin
      if (!cmd || accept)                        stall_cnt <= '0;
      else if (stall_cnt < SC_W'(WAIT_CYCLES))   stall_cnt <= stall_cnt + SC_W'(1);

      if (rd_accept && !avs_readdatavalid)       pending <= pending + PN_W'(1);
      else if (!rd_accept && avs_readdatavalid)  pending <= pending - PN_W'(1);

      if (rd_accept) rd_count <= rd_count + 32'd1;
      if (wr_accept) wr_count <= wr_count + 32'd1;

      if (accept && !in_range)            err_flags[ERR_RANGE] <= 1'b1;
      if (accept && avs_read && avs_write) err_flags[ERR_RDWR] <= 1'b1;
      if (accept && load_we)              err_flags[ERR_LOAD]  <= 1'b1;
    end
  end

  avs_read_pipe #(
    .DATA_W (DATA_W),
    .LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_accept),
    .in_data  (rd_word),
    .out_valid(avs_readdatavalid),
    .out_data (avs_readdata)
  );

endmodule

// File: tb/tb_avalon_mm_mem_slave.sv
// Directed bench: instance A uses default timing, instance B is zero-wait
// with a deep read latency and a small outstanding-read limit.
module tb_avalon_mm_mem_slave;

  localparam logic [255:0] DN0 = {8{32'hD0D0_0000}};
  localparam logic [255:0] DN1 = {8{32'hD1D1_1111}};
  localparam logic [255:0] A5  = {32{8'hA5}};
  localparam logic [255:0] XV  = {8{32'h7E07_E07E}};
  localparam logic [255:0] YV  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] ZV  = {8{32'h5A5A_0F0F}};
  localparam logic [255:0] WV  = {8{32'h1234_5678}};
  localparam logic [255:0] LV  = {8{32'hC0DE_CAFE}};
  localparam logic [255:0] QV  = {8{32'h0BAD_F00D}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic         a_reset, a_read, a_write, a_waitrequest, a_readdatavalid, a_load_we;
  logic [31:0]  a_address, a_rd_count, a_wr_count;
  logic [255:0] a_writedata, a_readdata, a_load_data, a_peek_data;
  logic [5:0]   a_load_index, a_peek_index;
  logic [2:0]   a_err_flags;

  logic         b_reset, b_read, b_write, b_waitrequest, b_readdatavalid, b_load_we;
  logic [31:0]  b_address, b_rd_count, b_wr_count;
  logic [255:0] b_writedata, b_readdata, b_load_data, b_peek_data;
  logic [5:0]   b_load_index, b_peek_index;
  logic [2:0]   b_err_flags;

  avalon_mm_mem_slave dut_a (
    .clk(clk), .reset(a_reset), .avs_address(a_address), .avs_read(a_read),
    .avs_write(a_write), .avs_writedata(a_writedata), .avs_waitrequest(a_waitrequest),
    .avs_readdata(a_readdata), .avs_readdatavalid(a_readdatavalid),
    .load_we(a_load_we), .load_index(a_load_index), .load_data(a_load_data),
    .peek_index(a_peek_index), .peek_data(a_peek_data),
    .rd_count(a_rd_count), .wr_count(a_wr_count), .err_flags(a_err_flags)
  );

  avalon_mm_mem_slave #(
    .WAIT_CYCLES(0), .READ_LATENCY(4), .MAX_PENDING(2)
  ) dut_b (
    .clk(clk), .reset(b_reset), .avs_address(b_address), .avs_read(b_read),
    .avs_write(b_write), .avs_writedata(b_writedata), .avs_waitrequest(b_waitrequest),
    .avs_readdata(b_readdata), .avs_readdatavalid(b_readdatavalid),
    .load_we(b_load_we), .load_index(b_load_index), .load_data(b_load_data),
    .peek_index(b_peek_index), .peek_data(b_peek_data),
    .rd_count(b_rd_count), .wr_count(b_wr_count), .err_flags(b_err_flags)
  );

  typedef struct {
    int           kind;      // 1 = write, 2 = read
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_rd;
    logic [5:0]   peek;
    logic [255:0] exp_peek;
    logic [2:0]   exp_err;
    int unsigned  exp_rc;
    int unsigned  exp_wc;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic [5:0] i, input logic [255:0] d);
    a_load_we = 1'b1; a_load_index = i; a_load_data = d;
    tick();
    a_load_we = 1'b0;
  endtask

  task automatic a_wr(input logic [31:0] addr, input logic [255:0] d);
    bit got = 0;
    a_address = addr; a_writedata = d; a_write = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = !a_waitrequest;
      tick();
    end
    a_write = 1'b0;
    chk("wr_accept", got, 1);
  endtask

  task automatic a_rd(input logic [31:0] addr, input bit both, input logic [255:0] wd,
                      output logic [255:0] data);
    bit got = 0;
    a_address = addr; a_read = 1'b1; a_write = both; a_writedata = wd;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = !a_waitrequest;
      tick();
    end
    a_read = 1'b0; a_write = 1'b0;
    chk("rd_accept", got, 1);
    got = 0; data = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_readdatavalid) begin got = 1; data = a_readdata; end
      tick();
    end
    chk("rd_valid", got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rd;
    bit saw;

    tbl[0] = '{1, 32'h40,  A5, '0,  6'd2,  A5,  3'b000, 1, 1};
    tbl[1] = '{2, 32'h40,  '0, A5,  6'd2,  A5,  3'b000, 2, 1};
    tbl[2] = '{2, 32'h3F,  '0, DN1, 6'd1,  DN1, 3'b000, 3, 1};
    tbl[3] = '{1, 32'h7E0, XV, '0,  6'd63, XV,  3'b000, 3, 2};
    tbl[4] = '{2, 32'h7E0, '0, XV,  6'd63, XV,  3'b000, 4, 2};
    tbl[5] = '{2, 32'h800, '0, '0,  6'd0,  DN0, 3'b001, 5, 2};
    tbl[6] = '{1, 32'h800, YV, '0,  6'd0,  DN0, 3'b001, 5, 3};
    tbl[7] = '{2, 32'h00,  '0, DN0, 6'd0,  DN0, 3'b001, 6, 3};

    {a_reset, a_read, a_write, a_load_we} = 4'b1000;
    {b_reset, b_read, b_write, b_load_we} = 4'b1000;
    a_address = '0; a_writedata = '0; a_load_index = '0; a_load_data = '0; a_peek_index = '0;
    b_address = '0; b_writedata = '0; b_load_index = '0; b_load_data = '0; b_peek_index = '0;
    repeat (3) tick();
    a_reset = 1'b0; b_reset = 1'b0;

    @(negedge clk);
    chk("rst_a_rdv", a_readdatavalid, 0);
    chk("rst_a_rdata", a_readdata, '0);
    chk("rst_a_counts", {a_rd_count, a_wr_count}, '0);
    chk("rst_a_err", a_err_flags, 0);
    chk("rst_a_wait", a_waitrequest, 0);
    chk("rst_b_state", {b_readdatavalid, b_readdata, b_rd_count, b_wr_count, b_err_flags}, '0);
    tick();

    // Stalled single read: waitrequest T..T+2, accept T+3, data at T+5.
    a_load(6'd0, DN0);
    a_load(6'd1, DN1);
    a_address = 32'h20; a_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_wait_hi_%0d", k), a_waitrequest, 1);
      tick();
    end
    @(negedge clk);
    chk("stall_accept", a_waitrequest, 0);
    tick();
    a_read = 1'b0;
    @(negedge clk);
    chk("stall_rdv_early", a_readdatavalid, 0);
    tick();
    @(negedge clk);
    chk("stall_rdv", a_readdatavalid, 1);
    chk("stall_rdata", a_readdata, DN1);
    chk("stall_rd_count", a_rd_count, 1);
    tick();
    @(negedge clk);
    chk("stall_rdv_one_cycle", a_readdatavalid, 0);
    tick();

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].kind == 1) a_wr(tbl[i].addr, tbl[i].wdata);
      else begin
        a_rd(tbl[i].addr, 0, '0, rd);
        chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      end
      a_peek_index = tbl[i].peek;
      #1;
      chk($sformatf("v%0d_peek", i), a_peek_data, tbl[i].exp_peek);
      chk($sformatf("v%0d_err", i), a_err_flags, tbl[i].exp_err);
      chk($sformatf("v%0d_rd_count", i), a_rd_count, tbl[i].exp_rc);
      chk($sformatf("v%0d_wr_count", i), a_wr_count, tbl[i].exp_wc);
    end

    // Read and write together behave as a read only.
    a_rd(32'h00, 1, ZV, rd);
    a_peek_index = 6'd0;
    #1;
    chk("rw_rdata", rd, DN0);
    chk("rw_peek", a_peek_data, DN0);
    chk("rw_counts", {a_rd_count, a_wr_count}, {32'd7, 32'd3});
    chk("rw_err", a_err_flags, 3'b011);

    // Load port collides with an accepted write to the same word.
    tick();
    a_address = 32'h00; a_writedata = WV; a_write = 1'b1;
    repeat (3) tick();
    a_load_we = 1'b1; a_load_index = 6'd0; a_load_data = LV;
    @(negedge clk);
    chk("ld_wr_accept", a_waitrequest, 0);
    tick();
    a_write = 1'b0; a_load_we = 1'b0;
    #1;
    chk("ld_wr_peek", a_peek_data, LV);
    chk("ld_wr_err", a_err_flags, 3'b111);
    chk("ld_wr_wr_count", a_wr_count, 4);

    // Reset one cycle after a read accept drops the in-flight read.
    a_address = 32'h20; a_read = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mid_accept", a_waitrequest, 0);
    tick();
    a_read = 1'b0; a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    saw = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_readdatavalid) saw = 1;
      tick();
    end
    chk("rst_mid_no_rdv", saw, 0);
    chk("rst_mid_counts", {a_rd_count, a_wr_count}, '0);
    chk("rst_mid_err", a_err_flags, 0);
    chk("rst_mid_pending", dut_a.pending, 0);
    chk("rst_mid_mem_kept", a_peek_data, LV);

    // Instance B: zero wait, latency 4, two outstanding reads.
    for (int k = 0; k < 5; k++) begin
      b_load_we = 1'b1; b_load_index = 6'(k); b_load_data = {8{32'(32'hB000_0000 + k)}};
      tick();
    end
    b_load_we = 1'b0;
    b_read = 1'b1; b_address = 32'h00;
    @(negedge clk); chk("pipe_t0_accept", b_waitrequest, 0); tick();
    b_address = 32'h20;
    @(negedge clk); chk("pipe_t1_accept", b_waitrequest, 0); tick();
    b_address = 32'h40;
    @(negedge clk); chk("pipe_t2_full", b_waitrequest, 1); tick();
    @(negedge clk);
    chk("pipe_t3_full", b_waitrequest, 1);
    chk("pipe_t3_rdv", b_readdatavalid, 0);
    tick();
    @(negedge clk);
    chk("pipe_t4_rdv", b_readdatavalid, 1);
    chk("pipe_t4_rdata", b_readdata, {8{32'hB000_0000}});
    chk("pipe_t4_accept", b_waitrequest, 0);
    tick();
    b_address = 32'h60;
    @(negedge clk);
    chk("pipe_t5_rdata", {b_readdatavalid, b_readdata}, {1'b1, {8{32'hB000_0001}}});
    chk("pipe_t5_accept", b_waitrequest, 0);
    chk("pipe_t5_rd_count", b_rd_count, 3);
    tick();
    b_read = 1'b0;
    @(negedge clk); chk("pipe_t6_rdv", b_readdatavalid, 0); tick();
    tick();
    @(negedge clk);
    chk("pipe_t8_rdata", {b_readdatavalid, b_readdata}, {1'b1, {8{32'hB000_0002}}});
    tick();
    @(negedge clk);
    chk("pipe_t9_rdata", {b_readdatavalid, b_readdata}, {1'b1, {8{32'hB000_0003}}});
    chk("pipe_t9_rd_count", b_rd_count, 4);
    tick();

    // Read accepted the cycle after a write to the same word.
    b_write = 1'b1; b_address = 32'h80; b_writedata = QV;
    @(negedge clk); chk("raw_wr_accept", b_waitrequest, 0); tick();
    b_write = 1'b0; b_read = 1'b1;
    @(negedge clk); chk("raw_rd_accept", b_waitrequest, 0); tick();
    b_read = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("raw_rdata", {b_readdatavalid, b_readdata}, {1'b1, QV});
    chk("raw_wr_count", b_wr_count, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
